// File: rtl/pio_pkg.sv
// Shared definitions for the PIO state-machine sequencer: FSM states, default
// address width and the position of the delay/side-set field in an instruction.
package pio_pkg;

    localparam int ADDR_W_DEFAULT = 5;

    localparam int FIELD_LSB = 8;
    localparam int FIELD_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2,
        DELAY = 2'd3
    } sm_state_t;

endpackage

// File: rtl/pio_field_split.sv
// Splits the 5-bit delay/side-set field into its delay count and side-set value
// according to the configured side-set width and optional-enable mode.
module pio_field_split
    import pio_pkg::*;
(
    input  logic [FIELD_W-1:0] field,
    input  logic [2:0]         sideset_bits,
    input  logic               sideset_opt,
    output logic [FIELD_W-1:0] delay,
    output logic [FIELD_W-1:0] side_val,
    output logic               side_present
);

    logic [2:0]         bits;
    logic [2:0]         dw;
    logic [FIELD_W-1:0] dmask;
    logic [FIELD_W-1:0] raw;

    always_comb begin
        // Widths above five cannot be encoded in the field; treat them as five.
        bits         = (sideset_bits > 3'd5) ? 3'd5 : sideset_bits;
        dw           = 3'd5 - bits;
        dmask        = 5'((6'd1 << dw) - 6'd1);
        delay        = field & dmask;
        raw          = field >> dw;
        side_present = 1'b0;
        side_val     = '0;
        if (bits != 3'd0) begin
            if (sideset_opt) begin
                side_present = field[FIELD_W-1];
                side_val     = raw & ~(5'd1 << (bits - 3'd1));
            end else begin
                side_present = 1'b1;
                side_val     = raw;
            end
        end
    end

endmodule

// File: rtl/pio_sm_sequencer.sv
// Per-state-machine instruction sequencer: program counter, stall/delay handling,
// jumps, wrap window and side-set strobe. Optional feature macro: PIO_EXEC_INJECT_EN.
module pio_sm_sequencer
    import pio_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              restart_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] wrap_top_i,
    input  logic [ADDR_W-1:0] wrap_bottom_i,
    input  logic [2:0]        sideset_bits_i,
    input  logic              sideset_opt_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [15:0]       imem_data_i,
    output logic [15:0]       instr_o,
    output logic              issue_o,
    input  logic              stall_i,
    input  logic              jmp_taken_i,
    input  logic [ADDR_W-1:0] jmp_target_i,
    output logic [4:0]        side_val_o,
    output logic              side_valid_o,
    output logic [ADDR_W-1:0] pc_o,
`ifdef PIO_EXEC_INJECT_EN
    input  logic              exec_valid_i,
    input  logic [15:0]       exec_instr_i,
    output logic              exec_ready_o,
`endif
    output logic [1:0]        state_o
);

    sm_state_t         state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, pc_seq;
    logic [4:0]        cnt, cnt_next;
    logic [4:0]        delay;
    logic [4:0]        side_val;
    logic              side_present;
    logic              injected;

    assign issue_o     = en_i && ((state == ISSUE) || (state == STALL));
    assign imem_addr_o = pc;
    assign pc_o        = pc;
    assign state_o     = state;

`ifdef PIO_EXEC_INJECT_EN
    // Handshake: an injected word transfers when exec_valid_i and exec_ready_o are
    // both high on a rising edge; valid must not depend on ready, ready only
    // depends on enable and state.
    logic        accept;
    logic        inj_hold;
    logic [15:0] inj_word;

    assign exec_ready_o = en_i && (state == ISSUE);
    assign accept       = exec_ready_o && exec_valid_i;
    assign injected     = accept || ((state == STALL) && inj_hold);
    assign instr_o      = accept ? exec_instr_i :
                          ((state == STALL) && inj_hold) ? inj_word : imem_data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_hold <= 1'b0;
            inj_word <= '0;
        end else begin
            if (restart_i) begin
                inj_hold <= 1'b0;
            end else if (issue_o) begin
                inj_hold <= stall_i && injected;
            end
            if (accept) begin
                inj_word <= exec_instr_i;
            end
        end
    end
`else
    assign injected = 1'b0;
    assign instr_o  = imem_data_i;
`endif

    pio_field_split u_split (
        .field        (instr_o[FIELD_LSB +: FIELD_W]),
        .sideset_bits (sideset_bits_i),
        .sideset_opt  (sideset_opt_i),
        .delay        (delay),
        .side_val     (side_val),
        .side_present (side_present)
    );

    assign side_valid_o = en_i && (state == ISSUE) && side_present;
    assign side_val_o   = (issue_o && side_present) ? side_val : 5'd0;

    // The wrap check looks at the pc of the retiring instruction, not pc+1.
    assign pc_seq = (pc == wrap_top_i) ? wrap_bottom_i : pc + ADDR_W'(1);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        cnt_next   = cnt;
        if (restart_i) begin
            pc_next    = start_addr_i;
            cnt_next   = '0;
            state_next = en_i ? ISSUE : IDLE;
        end else if (en_i) begin
            case (state)
                IDLE: state_next = ISSUE;
                ISSUE, STALL: begin
                    if (stall_i) begin
                        state_next = STALL;
                    end else begin
                        if (jmp_taken_i) begin
                            pc_next = jmp_target_i;
                        end else if (!injected) begin
                            pc_next = pc_seq;
                        end
                        if (delay != 5'd0) begin
                            state_next = DELAY;
                            cnt_next   = delay;
                        end else begin
                            state_next = ISSUE;
                        end
                    end
                end
                DELAY: begin
                    if (cnt <= 5'd1) begin
                        cnt_next   = '0;
                        state_next = ISSUE;
                    end else begin
                        cnt_next = cnt - 5'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_pio_sm_sequencer.sv
// Self-checking bench for pio_sm_sequencer: decode table, directed multi-cycle
// sequences and a randomized run against a cycle-level behavioural model.
module tb_pio_sm_sequencer;

    localparam int W = 28;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i, restart_i, sideset_opt_i, stall_i, jmp_taken_i;
    logic [4:0]  start_addr_i, wrap_top_i, wrap_bottom_i, jmp_target_i;
    logic [2:0]  sideset_bits_i;
    logic [4:0]  imem_addr_o, pc_o, side_val_o;
    logic [15:0] imem_data_i, instr_o;
    logic        issue_o, side_valid_o;
    logic [1:0]  state_o;
`ifdef PIO_EXEC_INJECT_EN
    logic        exec_valid_i, exec_ready_o;
    logic [15:0] exec_instr_i;
`endif

    logic [15:0] imem [32];
    assign imem_data_i = imem[imem_addr_o];

    always #5 clk = ~clk;

    pio_sm_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (en_i),
        .restart_i      (restart_i),
        .start_addr_i   (start_addr_i),
        .wrap_top_i     (wrap_top_i),
        .wrap_bottom_i  (wrap_bottom_i),
        .sideset_bits_i (sideset_bits_i),
        .sideset_opt_i  (sideset_opt_i),
        .imem_addr_o    (imem_addr_o),
        .imem_data_i    (imem_data_i),
        .instr_o        (instr_o),
        .issue_o        (issue_o),
        .stall_i        (stall_i),
        .jmp_taken_i    (jmp_taken_i),
        .jmp_target_i   (jmp_target_i),
        .side_val_o     (side_val_o),
        .side_valid_o   (side_valid_o),
        .pc_o           (pc_o),
`ifdef PIO_EXEC_INJECT_EN
        .exec_valid_i   (exec_valid_i),
        .exec_instr_i   (exec_instr_i),
        .exec_ready_o   (exec_ready_o),
`endif
        .state_o        (state_o)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];

    typedef struct {
        logic [2:0] bits;
        logic       opt;
        logic [4:0] field;
        logic [4:0] exp_val;
        logic       exp_sv;
        int         exp_delay;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart(input logic [4:0] addr);
        restart_i    = 1'b1;
        start_addr_i = addr;
        en_i         = 1'b1;
        tick();
        restart_i = 1'b0;
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
        sideset_bits_i = 3'd0;
        sideset_opt_i  = 1'b0;
        wrap_top_i     = 5'd31;
        wrap_bottom_i  = 5'd0;
        stall_i        = 1'b0;
        jmp_taken_i    = 1'b0;
    endtask

    // Decode straight from the field rules using integer arithmetic.
    function automatic void model_decode(input logic [15:0] ins, input int bits, input bit opt,
                                         output bit present, output int val, output int dly);
        int field;
        int raw;
        field = int'(ins[12:8]);
        dly   = field % (1 << (5 - bits));
        raw   = field / (1 << (5 - bits));
        if (bits == 0) begin
            present = 1'b0;
            val     = 0;
        end else if (opt) begin
            present = (field >= 16);
            val     = raw % (1 << (bits - 1));
        end else begin
            present = 1'b1;
            val     = raw;
        end
    endfunction

    initial begin
        int n;
        int seen_sv;
        int exp_pc [5];
        int mpc, mdelay, mval, mdly, bits;
        bit mstarted, mfresh, mpres, opt;
        bit e_issue, e_sv;
        logic [W-1:0] exp_v, act_v;

        vecs[0] = '{3'd0, 1'b0, 5'b00011, 5'd0,  1'b0, 3};
        vecs[1] = '{3'd3, 1'b1, 5'b11010, 5'd2,  1'b1, 2};
        vecs[2] = '{3'd3, 1'b1, 5'b01010, 5'd0,  1'b0, 2};
        vecs[3] = '{3'd2, 1'b0, 5'b10001, 5'd2,  1'b1, 1};
        vecs[4] = '{3'd5, 1'b0, 5'b10110, 5'd22, 1'b1, 0};
        vecs[5] = '{3'd5, 1'b1, 5'b11111, 5'd15, 1'b1, 0};
        vecs[6] = '{3'd1, 1'b1, 5'b10000, 5'd0,  1'b1, 0};
        vecs[7] = '{3'd1, 1'b0, 5'b01111, 5'd0,  1'b1, 15};
        vecs[8] = '{3'd4, 1'b1, 5'b01100, 5'd0,  1'b0, 0};

        rst_n = 1'b0; en_i = 1'b0; restart_i = 1'b0; start_addr_i = '0; jmp_target_i = '0;
`ifdef PIO_EXEC_INJECT_EN
        exec_valid_i = 1'b0; exec_instr_i = '0;
`endif
        clear_prog();
        imem[0] = 16'hBEEF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_pc", 32'(pc_o), 32'd0);
        check("reset_issue", 32'(issue_o), 32'd0);
        check("reset_side_valid", 32'(side_valid_o), 32'd0);
        check("reset_side_val", 32'(side_val_o), 32'd0);
        check("reset_instr", 32'(instr_o), 32'hBEEF);
        rst_n = 1'b1;
        tick(); tick();
        check("idle_no_issue", 32'(issue_o), 32'd0);
        en_i = 1'b1;
        #1;
        check("idle_en_same_cycle", 32'(issue_o), 32'd0);
        tick();
        check("first_issue_latency", 32'(issue_o), 32'd1);
        check("first_issue_pc", 32'(pc_o), 32'd0);

        // Decode table
        for (int v = 0; v < 9; v++) begin
            clear_prog();
            sideset_bits_i = vecs[v].bits;
            sideset_opt_i  = vecs[v].opt;
            imem[0] = {3'b000, vecs[v].field, 8'h00};
            do_restart(5'd0);
            check($sformatf("vec%0d_issue", v), 32'(issue_o), 32'd1);
            check($sformatf("vec%0d_side_val", v), 32'(side_val_o), 32'(vecs[v].exp_val));
            check($sformatf("vec%0d_side_valid", v), 32'(side_valid_o), 32'(vecs[v].exp_sv));
            tick();
            n = 0;
            while (issue_o == 1'b0 && n < 40) begin
                n++;
                tick();
            end
            check($sformatf("vec%0d_delay", v), 32'(n), 32'(vecs[v].exp_delay));
        end

        // Sequential run through the wrap window
        clear_prog();
        wrap_bottom_i = 5'd2;
        wrap_top_i    = 5'd4;
        exp_pc = '{2, 3, 4, 2, 3};
        do_restart(5'd2);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wrap_pc%0d", i), 32'(pc_o), 32'(exp_pc[i]));
            check($sformatf("wrap_issue%0d", i), 32'(issue_o), 32'd1);
            tick();
        end

        // Delay of 3: issue pattern 1,0,0,0,1 with one pc advance
        clear_prog();
        imem[0] = 16'h0300;
        do_restart(5'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("delay3_issue%0d", i), 32'(issue_o), (i == 0 || i == 4) ? 32'd1 : 32'd0);
            if (i == 4) check("delay3_pc", 32'(pc_o), 32'd1);
            tick();
        end

        // Stall 3 cycles on a delay-1 instruction carrying side-set
        clear_prog();
        sideset_bits_i = 3'd3;
        imem[5] = 16'h1500;
        do_restart(5'd5);
        seen_sv = 0;
        for (int c = 0; c < 4; c++) begin
            stall_i = (c < 3);
            #1;
            check($sformatf("stall_instr%0d", c), 32'(instr_o), 32'h1500);
            check($sformatf("stall_issue%0d", c), 32'(issue_o), 32'd1);
            if (c == 0) check("stall_side_val", 32'(side_val_o), 32'd5);
            seen_sv += int'(side_valid_o);
            tick();
        end
        stall_i = 1'b0;
        check("stall_strobe_count", 32'(seen_sv), 32'd1);
        check("stall_delay_idle", 32'(issue_o), 32'd0);
        tick();
        check("stall_next_issue", 32'(issue_o), 32'd1);
        check("stall_next_pc", 32'(pc_o), 32'd6);

        // Enable dropped mid-delay freezes the remaining count
        clear_prog();
        imem[0] = 16'h0400;
        do_restart(5'd0);
        tick(); tick();
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("freeze_issue%0d", i), 32'(issue_o), 32'd0);
            check($sformatf("freeze_pc%0d", i), 32'(pc_o), 32'd1);
        end
        en_i = 1'b1;
        #1;
        n = 0;
        while (issue_o == 1'b0 && n < 40) begin
            n++;
            tick();
        end
        check("freeze_resume_idle", 32'(n), 32'd3);

        // Restart while disabled discards the remaining delay
        clear_prog();
        imem[0] = 16'h0A00;
        do_restart(5'd0);
        tick(); tick();
        en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("dis_issue%0d", i), 32'(issue_o), 32'd0);
        end
        restart_i    = 1'b1;
        start_addr_i = 5'd7;
        tick();
        restart_i = 1'b0;
        #1;
        check("rst_dis_pc", 32'(pc_o), 32'd7);
        check("rst_dis_issue", 32'(issue_o), 32'd0);
        en_i = 1'b1;
        #1;
        check("rst_dis_idle_first", 32'(issue_o), 32'd0);
        tick();
        check("rst_dis_reissue", 32'(issue_o), 32'd1);
        check("rst_dis_reissue_pc", 32'(pc_o), 32'd7);

        // Jump beats wrap; a jump onto wrap_top then wraps normally
        clear_prog();
        wrap_bottom_i = 5'd2;
        wrap_top_i    = 5'd4;
        do_restart(5'd4);
        jmp_taken_i  = 1'b1;
        jmp_target_i = 5'd9;
        tick();
        check("jmp_beats_wrap", 32'(pc_o), 32'd9);
        jmp_target_i = 5'd4;
        tick();
        check("jmp_to_top", 32'(pc_o), 32'd4);
        jmp_taken_i = 1'b0;
        tick();
        check("wrap_after_jmp", 32'(pc_o), 32'd2);

`ifdef PIO_EXEC_INJECT_EN
        clear_prog();
        imem[3] = 16'h0011;
        do_restart(5'd3);
        exec_valid_i = 1'b1;
        exec_instr_i = 16'hE0FF;
        #1;
        check("inj_ready", 32'(exec_ready_o), 32'd1);
        check("inj_instr", 32'(instr_o), 32'hE0FF);
        tick();
        exec_valid_i = 1'b0;
        #1;
        check("inj_pc_held", 32'(pc_o), 32'd3);
        check("inj_mem_back", 32'(instr_o), 32'h0011);
`endif

        // Randomized run against the behavioural model
        for (int i = 0; i < 32; i++) imem[i] = 16'($urandom);
        wrap_bottom_i = 5'($urandom_range(0, 31));
        wrap_top_i    = 5'($urandom_range(0, 31));
        bits = $urandom_range(0, 5);
        opt  = 1'($urandom_range(0, 1));
        sideset_bits_i = 3'(bits);
        sideset_opt_i  = opt;
        do_restart(5'd0);
        mpc = 0; mdelay = 0; mstarted = 1'b1; mfresh = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 249) begin
                bits = $urandom_range(0, 5);
                opt  = 1'($urandom_range(0, 1));
                sideset_bits_i = 3'(bits);
                sideset_opt_i  = opt;
            end
            en_i         = ($urandom_range(0, 99) < 85);
            stall_i      = ($urandom_range(0, 99) < 25);
            restart_i    = ($urandom_range(0, 99) < 2);
            start_addr_i = 5'($urandom_range(0, 31));
            jmp_taken_i  = ($urandom_range(0, 99) < 15);
            jmp_target_i = 5'($urandom_range(0, 31));
            #1;
            model_decode(imem[mpc], bits, opt, mpres, mval, mdly);
            e_issue = en_i && mstarted && (mdelay == 0);
            e_sv    = e_issue && mfresh && mpres;
            exp_q.push_back({e_issue, 5'(mpc), e_sv, (e_issue && mpres) ? 5'(mval) : 5'd0, imem[mpc]});
            act_v = {issue_o, pc_o, side_valid_o, side_val_o, instr_o};
            exp_v = exp_q.pop_front();
            check($sformatf("rand_cyc%0d", cyc), 32'(act_v), 32'(exp_v));
            if (restart_i) begin
                mpc = int'(start_addr_i); mdelay = 0; mstarted = en_i; mfresh = 1'b1;
            end else if (en_i) begin
                if (!mstarted) begin
                    mstarted = 1'b1;
                end else if (mdelay > 0) begin
                    mdelay--;
                end else if (stall_i) begin
                    mfresh = 1'b0;
                end else begin
                    if (jmp_taken_i) mpc = int'(jmp_target_i);
                    else if (mpc == int'(wrap_top_i)) mpc = int'(wrap_bottom_i);
                    else mpc = (mpc + 1) % 32;
                    mdelay = mdly;
                    mfresh = 1'b1;
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
